audio_channel_sched: RTL and testbench

- Per-sample sequencer and mixer for the 8 audio channels.
- On each sample tick it visits every enabled channel in order, fetches one 8-bit sample through the per-channel audio read cache, scales it by the channel volume and accumulates it.
- It advances each channel's fixed-point playback position and handles end-of-sample stop or loop.
- It emits one saturated 16-bit mixed sample per tick. Configuration comes over a simple register-write port from the CPU bus.

---
 rtl/audio_pkg.sv | 45 ++++
 rtl/audio_mix_sat.sv | 46 ++++
 rtl/audio_channel_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_audio_channel_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio channel sequencer/mixer.
// Holds FSM state encodings, register indices, channel config layout and saturation helper.
package audio_pkg;

   localparam int NUM_CHANNELS = 8;

   typedef logic [2:0] sched_state_t;

   localparam sched_state_t ST_IDLE   = 3'd0;
   localparam sched_state_t ST_SELECT = 3'd1;
   localparam sched_state_t ST_FETCH  = 3'd2;
   localparam sched_state_t ST_ACCUM  = 3'd3;
   localparam sched_state_t ST_NEXT   = 3'd4;
   localparam sched_state_t ST_DONE   = 3'd5;

   localparam logic [2:0] REG_START   = 3'd0;
   localparam logic [2:0] REG_LENGTH  = 3'd1;
   localparam logic [2:0] REG_LOOP    = 3'd2;
   localparam logic [2:0] REG_STEP    = 3'd3;
   localparam logic [2:0] REG_VOLUME  = 3'd4;
   localparam logic [2:0] REG_CONTROL = 3'd5;
   localparam logic [2:0] REG_CLEAR   = 3'd7;

   typedef struct packed {
      logic [25:0] start;
      logic [15:0] length;
      logic [15:0] loop_start;
      logic [19:0] step;
      logic [7:0]  volume;
      logic        loop_en;
      logic        enable;
   } chan_cfg_t;

   // Clamp the 19-bit accumulator into the signed 16-bit output range.
   function automatic logic [15:0] sat16(input logic [18:0] value);
      if ((value[18:15] == 4'b0000) || (value[18:15] == 4'b1111)) begin
         return value[15:0];
      end else if (value[18]) begin
         return 16'h8000;
      end else begin
         return 16'h7FFF;
      end
   endfunction

endpackage

// File: rtl/audio_mix_sat.sv
// Volume scaling, 19-bit signed mix accumulator and final output saturation.
module audio_mix_sat
   import audio_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        accum_en,
   input  logic [15:0] sample,
   input  logic [7:0]  volume,
   output logic [15:0] sat_sample
);

   logic signed [24:0] sample_ext_s;
   logic signed [24:0] volume_ext_s;
   logic signed [24:0] product_s;
   logic signed [16:0] scaled_s;
   logic signed [18:0] acc_next_s;
   logic signed [18:0] acc_r;

   // Scale the signed sample by the unsigned volume and form the next accumulator value.
   always_comb begin
      sample_ext_s = {{9{sample[15]}}, sample};
      volume_ext_s = {17'd0, volume};
      product_s    = sample_ext_s * volume_ext_s;
      scaled_s     = product_s[24:8];
      acc_next_s   = acc_r + {{2{scaled_s[16]}}, scaled_s};
   end

   // Accumulator: cleared at the start of each sample period, updated once per channel.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_r <= 19'sd0;
      end else if (clear) begin
         acc_r <= 19'sd0;
      end else if (accum_en) begin
         acc_r <= acc_next_s;
      end
   end

   // Saturated view of the accumulator for the output register.
   always_comb begin
      sat_sample = sat16(acc_r);
   end

endmodule

// File: rtl/audio_channel_sched.sv
// Per-sample channel sequencer: walks the 8 channels, fetches one byte each through the
// audio cache, mixes them and advances the fixed-point playback positions.
module audio_channel_sched
   import audio_pkg::*;
#(
   parameter int FETCH_TIMEOUT = 64
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        sample_tick,
   input  logic        cfg_write,
   input  logic [2:0]  cfg_channel,
   input  logic [2:0]  cfg_reg,
   input  logic [31:0] cfg_wdata,
   output logic        mem_request,
   output logic [25:0] mem_address,
   output logic [2:0]  current_channel,
   input  logic        mem_valid,
   input  logic [15:0] mem_data,
   output logic [15:0] audio_sample,
   output logic        audio_valid,
   output logic [7:0]  channel_active,
   output logic        overrun,
   output logic [7:0]  timeout_count
);

   localparam int TMO_W = $clog2(FETCH_TIMEOUT) + 1;

   chan_cfg_t        cfg_r [NUM_CHANNELS];
   logic [31:0]      pos_r [NUM_CHANNELS];
   sched_state_t     state_r;
   sched_state_t     state_s;
   logic [2:0]       chan_r;
   logic [TMO_W-1:0] tmo_cnt_r;
   logic [15:0]      sample_r;
   logic [15:0]      wk_len_r;
   logic [15:0]      wk_loop_start_r;
   logic [19:0]      wk_step_r;
   logic [25:0]      mem_address_r;
   logic             mem_request_r;
   logic [15:0]      audio_sample_r;
   logic             audio_valid_r;
   logic             overrun_r;
   logic [7:0]       timeout_count_r;

   logic             tmo_hit_s;
   logic             tmo_event_s;
   logic             clear_s;
   logic             mix_clear_s;
   logic             mix_accum_s;
   logic [15:0]      sat_sample_s;
   logic [31:0]      newpos_s;
   logic [31:0]      wrap_s;
   logic [31:0]      next_pos_s;
   logic             stop_s;
   logic [7:0]       active_s;
   logic             unused_s;

   assign unused_s = ^cfg_wdata[31:26];

   // Event decodes shared by the FSM and the status registers.
   always_comb begin
      tmo_hit_s   = (tmo_cnt_r == TMO_W'(FETCH_TIMEOUT - 1)) && !mem_valid;
      tmo_event_s = (state_r == ST_FETCH) && tmo_hit_s;
      clear_s     = cfg_write && (cfg_reg == REG_CLEAR);
      mix_clear_s = (state_r == ST_IDLE) && sample_tick;
      mix_accum_s = (state_r == ST_ACCUM);
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (sample_tick) state_s = ST_SELECT;
            else             state_s = ST_IDLE;
         end
         ST_SELECT: begin
            if (cfg_r[chan_r].enable) state_s = ST_FETCH;
            else                      state_s = ST_NEXT;
         end
         ST_FETCH: begin
            if (mem_valid || tmo_hit_s) state_s = ST_ACCUM;
            else                        state_s = ST_FETCH;
         end
         ST_ACCUM: state_s = ST_NEXT;
         ST_NEXT: begin
            if (chan_r == 3'd7) state_s = ST_DONE;
            else                state_s = ST_SELECT;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Position advance with loop wrap; length and loop start come from the per-tick snapshot.
   always_comb begin
      newpos_s = pos_r[chan_r] + {12'd0, wk_step_r};
      wrap_s   = {wk_len_r - wk_loop_start_r, 16'd0};
      if (newpos_s[31:16] >= wk_len_r) begin
         if (cfg_r[chan_r].loop_en) begin
            next_pos_s = newpos_s - wrap_s;
            stop_s     = 1'b0;
         end else begin
            next_pos_s = newpos_s;
            stop_s     = 1'b1;
         end
      end else begin
         next_pos_s = newpos_s;
         stop_s     = 1'b0;
      end
   end

   // Channel registers and positions; CPU writes are placed last so they win over ACCUM.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            cfg_r[i] <= '0;
            pos_r[i] <= 32'd0;
         end
      end else begin
         if (state_r == ST_ACCUM) begin
            pos_r[chan_r] <= next_pos_s;
            if (stop_s) cfg_r[chan_r].enable <= 1'b0;
         end
         if (cfg_write) begin
            case (cfg_reg)
               REG_START:  cfg_r[cfg_channel].start <= cfg_wdata[25:0];
               REG_LENGTH: begin
                  cfg_r[cfg_channel].length <= cfg_wdata[15:0];
                  if (cfg_wdata[15:0] == 16'd0) cfg_r[cfg_channel].enable <= 1'b0;
               end
               REG_LOOP:   cfg_r[cfg_channel].loop_start <= cfg_wdata[15:0];
               REG_STEP:   cfg_r[cfg_channel].step <= cfg_wdata[19:0];
               REG_VOLUME: cfg_r[cfg_channel].volume <= cfg_wdata[7:0];
               REG_CONTROL: begin
                  cfg_r[cfg_channel].enable  <= cfg_wdata[0] && (cfg_r[cfg_channel].length != 16'd0);
                  cfg_r[cfg_channel].loop_en <= cfg_wdata[1];
                  if (cfg_wdata[0]) pos_r[cfg_channel] <= 32'd0;
               end
               default: ;
            endcase
         end
      end
   end

   // Sequencer datapath, cache interface and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         chan_r          <= 3'd0;
         tmo_cnt_r       <= '0;
         sample_r        <= 16'd0;
         wk_len_r        <= 16'd0;
         wk_loop_start_r <= 16'd0;
         wk_step_r       <= 20'd0;
         mem_address_r   <= 26'd0;
         mem_request_r   <= 1'b0;
         audio_sample_r  <= 16'd0;
         audio_valid_r   <= 1'b0;
         overrun_r       <= 1'b0;
         timeout_count_r <= 8'd0;
      end else begin
         state_r       <= state_s;
         mem_request_r <= (state_s == ST_FETCH);
         audio_valid_r <= (state_r == ST_DONE);
         case (state_r)
            ST_IDLE: begin
               if (sample_tick) chan_r <= 3'd0;
            end
            ST_SELECT: begin
               // Snapshot so mid-fetch writes to address/length/loop/step apply next tick.
               wk_len_r        <= cfg_r[chan_r].length;
               wk_loop_start_r <= cfg_r[chan_r].loop_start;
               wk_step_r       <= cfg_r[chan_r].step;
               mem_address_r   <= cfg_r[chan_r].start + {10'd0, pos_r[chan_r][31:16]};
               tmo_cnt_r       <= '0;
            end
            ST_FETCH: begin
               if (mem_valid)      sample_r  <= mem_data;
               else if (tmo_hit_s) sample_r  <= 16'd0;
               else                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            ST_NEXT: begin
               if (chan_r != 3'd7) chan_r <= chan_r + 3'd1;
            end
            ST_DONE: audio_sample_r <= sat_sample_s;
            default: ;
         endcase
         if (sample_tick && (state_r != ST_IDLE)) overrun_r <= 1'b1;
         else if (clear_s)                        overrun_r <= 1'b0;
         if (clear_s)                                            timeout_count_r <= 8'd0;
         else if (tmo_event_s && (timeout_count_r != 8'hFF))     timeout_count_r <= timeout_count_r + 8'd1;
      end
   end

   // Per-channel enable status.
   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         active_s[i] = cfg_r[i].enable;
      end
   end

   audio_mix_sat u_mix (
      .clock      (clock),
      .reset      (reset),
      .clear      (mix_clear_s),
      .accum_en   (mix_accum_s),
      .sample     (sample_r),
      .volume     (cfg_r[chan_r].volume),
      .sat_sample (sat_sample_s)
   );

   assign mem_request     = mem_request_r;
   assign mem_address     = mem_address_r;
   assign current_channel = chan_r;
   assign audio_sample    = audio_sample_r;
   assign audio_valid     = audio_valid_r;
   assign channel_active  = active_s;
   assign overrun         = overrun_r;
   assign timeout_count   = timeout_count_r;

endmodule

// File: tb/tb_audio_channel_sched.sv
// Self-checking bench for audio_channel_sched: a byte-memory cache model, a behavioural
// mixer model feeding an expected-sample queue, and per-scenario tasks.
module tb_audio_channel_sched;

   localparam int FETCH_TIMEOUT = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic        cfg_write = 1'b0;
   logic [2:0]  cfg_channel = 3'd0;
   logic [2:0]  cfg_reg = 3'd0;
   logic [31:0] cfg_wdata = 32'd0;
   logic        mem_request;
   logic [25:0] mem_address;
   logic [2:0]  current_channel;
   logic        mem_valid = 1'b0;
   logic [15:0] mem_data = 16'd0;
   logic [15:0] audio_sample;
   logic        audio_valid;
   logic [7:0]  channel_active;
   logic        overrun;
   logic [7:0]  timeout_count;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [int];
   bit          no_resp [8];
   logic [15:0] exp_q [$];

   logic [25:0] m_start [8];
   logic [15:0] m_len [8];
   logic [15:0] m_ls [8];
   logic [19:0] m_step [8];
   logic [7:0]  m_vol [8];
   bit          m_en [8];
   bit          m_loop [8];
   logic [31:0] m_pos [8];

   int          req_cycles [8];
   logic [25:0] addr_seen [8];

   audio_channel_sched #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) dut (
      .clock           (clock),
      .reset           (reset),
      .sample_tick     (sample_tick),
      .cfg_write       (cfg_write),
      .cfg_channel     (cfg_channel),
      .cfg_reg         (cfg_reg),
      .cfg_wdata       (cfg_wdata),
      .mem_request     (mem_request),
      .mem_address     (mem_address),
      .current_channel (current_channel),
      .mem_valid       (mem_valid),
      .mem_data        (mem_data),
      .audio_sample    (audio_sample),
      .audio_valid     (audio_valid),
      .channel_active  (channel_active),
      .overrun         (overrun),
      .timeout_count   (timeout_count)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] mem_rd(input logic [25:0] a);
      int k;
      k = int'(a);
      if (mem.exists(k)) return mem[k];
      else               return 8'h00;
   endfunction

   // Cache model: answers the cycle after it sees a request, unless the channel is muted.
   always @(posedge clock) begin
      mem_valid <= mem_request && !no_resp[current_channel];
      mem_data  <= {mem_rd(mem_address), mem_rd(mem_address)};
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_start[i] = 26'd0; m_len[i] = 16'd0; m_ls[i] = 16'd0; m_step[i] = 20'd0;
         m_vol[i] = 8'd0; m_en[i] = 1'b0; m_loop[i] = 1'b0; m_pos[i] = 32'd0;
         no_resp[i] = 1'b0;
      end
   endtask

   task automatic cfg_wr(input int ch, input int rg, input logic [31:0] d);
      @(posedge clock); #1;
      cfg_write = 1'b1; cfg_channel = 3'(ch); cfg_reg = 3'(rg); cfg_wdata = d;
      @(posedge clock); #1;
      cfg_write = 1'b0;
      case (rg)
         0: m_start[ch] = d[25:0];
         1: m_len[ch] = d[15:0];
         2: m_ls[ch] = d[15:0];
         3: m_step[ch] = d[19:0];
         4: m_vol[ch] = d[7:0];
         5: begin
            m_loop[ch] = d[1];
            m_en[ch]   = d[0] && (m_len[ch] != 16'd0);
            if (d[0]) m_pos[ch] = 32'd0;
         end
         default: ;
      endcase
   endtask

   task automatic model_tick(output logic [15:0] e);
      int acc;
      acc = 0;
      for (int ch = 0; ch < 8; ch++) begin
         if (m_en[ch]) begin
            logic [7:0]  b;
            logic [15:0] s;
            logic [31:0] np;
            b = no_resp[ch] ? 8'h00 : mem_rd(m_start[ch] + {10'd0, m_pos[ch][31:16]});
            s = {b, b};
            acc += (int'($signed(s)) * int'(m_vol[ch])) >>> 8;
            np = m_pos[ch] + {12'd0, m_step[ch]};
            if (np[31:16] >= m_len[ch]) begin
               if (m_loop[ch]) m_pos[ch] = np - {m_len[ch] - m_ls[ch], 16'h0000};
               else begin m_en[ch] = 1'b0; m_pos[ch] = np; end
            end else begin
               m_pos[ch] = np;
            end
         end
      end
      if (acc > 32767)       e = 16'h7FFF;
      else if (acc < -32768) e = 16'h8000;
      else                   e = 16'(acc);
   endtask

   task automatic tick_and_wait(output logic [15:0] got, output bit seen);
      for (int i = 0; i < 8; i++) begin req_cycles[i] = 0; addr_seen[i] = 26'd0; end
      @(posedge clock); #1 sample_tick = 1'b1;
      @(posedge clock); #1 sample_tick = 1'b0;
      seen = 1'b0;
      got  = 16'd0;
      for (int c = 0; c < 1500 && !seen; c++) begin
         @(negedge clock);
         if (mem_request) begin
            if (req_cycles[current_channel] == 0) addr_seen[current_channel] = mem_address;
            req_cycles[current_channel]++;
         end
         if (audio_valid) begin seen = 1'b1; got = audio_sample; end
      end
   endtask

   task automatic scored_tick(input string name, output logic [15:0] got);
      logic [15:0] e;
      bit seen;
      model_tick(e);
      exp_q.push_back(e);
      tick_and_wait(got, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: no audio_valid within cycle budget, expected %h", name, e);
      end else if (got !== e) begin
         errors++;
         $display("FAIL %s: audio_sample got %h expected %h", name, got, e);
      end
   endtask

   task automatic test_reset();
      model_clear();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checks++; if (audio_sample !== 16'd0)  begin errors++; $display("FAIL reset_sample: got %h expected 0000", audio_sample); end
      checks++; if (audio_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b expected 0", audio_valid); end
      checks++; if (mem_request !== 1'b0)    begin errors++; $display("FAIL reset_request: got %b expected 0", mem_request); end
      checks++; if (channel_active !== 8'd0) begin errors++; $display("FAIL reset_active: got %h expected 00", channel_active); end
      checks++; if (overrun !== 1'b0)        begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      checks++; if (timeout_count !== 8'd0)  begin errors++; $display("FAIL reset_tmo: got %h expected 00", timeout_count); end
      checks++; if (current_channel !== 3'd0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", current_channel); end
   endtask

   task automatic test_single_channel();
      logic [15:0] got;
      mem[32'h1000] = 8'd10; mem[32'h1001] = 8'd20; mem[32'h1002] = 8'd30; mem[32'h1003] = 8'd40;
      cfg_wr(0, 0, 32'h1000); cfg_wr(0, 1, 32'd4); cfg_wr(0, 3, 32'h10000);
      cfg_wr(0, 4, 32'd255); cfg_wr(0, 5, 32'd1);
      for (int t = 0; t < 5; t++) begin
         scored_tick("single_mix", got);
         if (t == 0) begin
            checks++;
            if (got !== 16'd2559) begin errors++; $display("FAIL single_first: got %0d expected 2559", got); end
         end
         if (t == 4) begin
            checks++;
            if (got !== 16'd0) begin errors++; $display("FAIL single_end: got %h expected 0000", got); end
         end
      end
      checks++;
      if (channel_active[0] !== 1'b0) begin errors++; $display("FAIL single_stop: active0 got %b expected 0", channel_active[0]); end
   endtask

   task automatic test_loop();
      int pos_a [7]  = '{0, 3, 6, 5, 4, 7, 6};
      int pos_b [10] = '{0, 1, 3, 4, 6, 7, 5, 6, 4, 5};
      logic [15:0] got;
      logic [25:0] off;
      for (int i = 0; i < 8; i++) mem[32'h2000 + i] = 8'(8'h11 * i + 8'h81);
      cfg_wr(1, 0, 32'h2000); cfg_wr(1, 1, 32'd8); cfg_wr(1, 2, 32'd4);
      cfg_wr(1, 3, 32'h30000); cfg_wr(1, 4, 32'd200); cfg_wr(1, 5, 32'd3);
      for (int t = 0; t < 7; t++) begin
         scored_tick("loop_mix", got);
         off = addr_seen[1] - 26'h2000;
         checks++;
         if (off !== 26'(pos_a[t])) begin errors++; $display("FAIL loop_pos tick %0d: got %0d expected %0d", t, off, pos_a[t]); end
      end
      cfg_wr(1, 3, 32'h18000); cfg_wr(1, 5, 32'd3);
      for (int t = 0; t < 10; t++) begin
         scored_tick("frac_mix", got);
         off = addr_seen[1] - 26'h2000;
         checks++;
         if (off !== 26'(pos_b[t])) begin errors++; $display("FAIL frac_pos tick %0d: got %0d expected %0d", t, off, pos_b[t]); end
      end
   endtask

   task automatic test_enable_zero_len();
      cfg_wr(4, 5, 32'd1);
      @(negedge clock);
      checks++;
      if (channel_active[4] !== 1'b0) begin errors++; $display("FAIL zero_len: active4 got %b expected 0", channel_active[4]); end
   endtask

   task automatic test_saturate();
      logic [15:0] got;
      for (int k = 0; k < 8; k++) begin
         mem[32'h4000 + k * 256] = 8'h7F; mem[32'h4001 + k * 256] = 8'h7F;
         mem[32'h6000 + k * 256] = 8'h80; mem[32'h6001 + k * 256] = 8'h80;
         cfg_wr(k, 0, 32'h4000 + k * 256); cfg_wr(k, 1, 32'd2); cfg_wr(k, 2, 32'd0);
         cfg_wr(k, 3, 32'h10000); cfg_wr(k, 4, 32'd255); cfg_wr(k, 5, 32'd3);
      end
      for (int t = 0; t < 2; t++) begin
         scored_tick("sat_pos_mix", got);
         checks++;
         if (got !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h expected 7fff", got); end
      end
      for (int k = 0; k < 8; k++) cfg_wr(k, 0, 32'h6000 + k * 256);
      for (int t = 0; t < 2; t++) begin
         scored_tick("sat_neg_mix", got);
         checks++;
         if (got !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h expected 8000", got); end
      end
      for (int k = 0; k < 8; k++) cfg_wr(k, 5, 32'd0);
   endtask

   task automatic test_timeout();
      logic [15:0] got;
      mem[32'h7100] = 8'h33; mem[32'h7101] = 8'hC4; mem[32'h7102] = 8'h5A; mem[32'h7103] = 8'h9E;
      no_resp[2] = 1'b1;
      cfg_wr(2, 0, 32'h7000); cfg_wr(2, 1, 32'd4); cfg_wr(2, 3, 32'h10000); cfg_wr(2, 4, 32'd128); cfg_wr(2, 5, 32'd1);
      cfg_wr(3, 0, 32'h7100); cfg_wr(3, 1, 32'd4); cfg_wr(3, 3, 32'h10000); cfg_wr(3, 4, 32'd200); cfg_wr(3, 5, 32'd3);
      scored_tick("tmo_mix", got);
      checks++; if (req_cycles[2] != FETCH_TIMEOUT) begin errors++; $display("FAIL tmo_cycles: got %0d expected %0d", req_cycles[2], FETCH_TIMEOUT); end
      checks++; if (timeout_count !== 8'd1) begin errors++; $display("FAIL tmo_count: got %0d expected 1", timeout_count); end
      checks++; if (addr_seen[3] !== 26'h7100) begin errors++; $display("FAIL tmo_next_chan: addr got %h expected 7100", addr_seen[3]); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL tmo_overrun: got %b expected 0", overrun); end
   endtask

   task automatic test_overrun();
      logic [15:0] e;
      logic [15:0] got;
      bit found;
      int nvalid;
      model_tick(e);
      exp_q.push_back(e);
      @(posedge clock); #1 sample_tick = 1'b1;
      @(posedge clock); #1 sample_tick = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clock);
         if (mem_request && (current_channel == 3'd2)) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL ovr_fetch: request on ch2 got none expected one"); end
      @(posedge clock); #1 sample_tick = 1'b1;
      @(posedge clock); #1 sample_tick = 1'b0;
      nvalid = 0;
      got = 16'd0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clock);
         if (audio_valid) begin nvalid++; got = audio_sample; end
      end
      e = exp_q.pop_front();
      checks++; if (nvalid != 1) begin errors++; $display("FAIL ovr_valids: got %0d expected 1", nvalid); end
      checks++; if (got !== e) begin errors++; $display("FAIL ovr_mix: got %h expected %h", got, e); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
      checks++; if (timeout_count !== 8'd2) begin errors++; $display("FAIL ovr_tmo: got %0d expected 2", timeout_count); end
      cfg_wr(5, 7, 32'd0);
      @(negedge clock);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_overrun: got %b expected 0", overrun); end
      checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL clr_tmo: got %0d expected 0", timeout_count); end
   endtask

   task automatic test_reset_mid_fetch();
      logic [15:0] got;
      bit found;
      bit seen;
      int total;
      @(posedge clock); #1 sample_tick = 1'b1;
      @(posedge clock); #1 sample_tick = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clock);
         if (mem_request) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rst_fetch: request got none expected one"); end
      reset = 1'b1;
      @(negedge clock);
      checks++; if (mem_request !== 1'b0)    begin errors++; $display("FAIL rst_request: got %b expected 0", mem_request); end
      checks++; if (channel_active !== 8'd0) begin errors++; $display("FAIL rst_active: got %h expected 00", channel_active); end
      checks++; if (current_channel !== 3'd0) begin errors++; $display("FAIL rst_chan: got %0d expected 0", current_channel); end
      @(posedge clock); #1 reset = 1'b0;
      model_clear();
      tick_and_wait(got, seen);
      total = 0;
      for (int i = 0; i < 8; i++) total += req_cycles[i];
      checks++; if (!seen) begin errors++; $display("FAIL rst_idle: audio_valid got none expected one"); end
      checks++; if (got !== 16'd0) begin errors++; $display("FAIL rst_mix: got %h expected 0000", got); end
      checks++; if (total != 0) begin errors++; $display("FAIL rst_no_fetch: request cycles got %0d expected 0", total); end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_loop();
      test_enable_zero_len();
      test_saturate();
      test_timeout();
      test_overrun();
      test_reset_mid_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
